mcpu_prog_loader: RTL and testbench

// Hardware program loader for MCPU: receives a byte stream (length, instruction words, checksum),

---
 rtl/mcpu_prog_loader_pkg.sv | 30 +++
 rtl/mcpu_word_packer.sv | 60 ++++++
 rtl/mcpu_prog_loader.sv | 187 ++++++++++++++++++
 tb/tb_mcpu_prog_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_prog_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mcpu_prog_loader_pkg : shared MCPU defaults and loader state encoding
// rev 1.0
// ---------------------------------------------------------------------------
package mcpu_prog_loader_pkg;

  localparam int MCPU_WORD_SIZE = 16;
  localparam int MCPU_ADDR_SIZE = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LEN   = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } ld_state_t;

  function automatic logic st_accepts(input ld_state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

  function automatic logic st_busy(input ld_state_t s);
    return (s == ST_CLEAR) || st_accepts(s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcpu_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mcpu_word_packer : MSB-first byte-to-word assembler; word_valid on last byte
// rev 1.0
// ---------------------------------------------------------------------------
module mcpu_word_packer #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_accept,
  input  logic [7:0]           in_byte,
  output logic [WORD_SIZE-1:0] word,
  output logic                 word_valid
);

  localparam int BYTES = WORD_SIZE / 8;

  generate
    if (BYTES > 1) begin : g_multi
      localparam int CW = $clog2(BYTES);
      localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

      logic [CW-1:0]          cnt_q, cnt_d;
      logic [WORD_SIZE-9:0]   sr_q, sr_d;
      logic                   last;

      // word is combinational so the loader can register it with the strobe
      always_comb begin
        word       = {sr_q, in_byte};
        last       = (cnt_q == LAST);
        word_valid = in_accept && last;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        if (clear) begin
          cnt_d = '0;
        end else if (in_accept) begin
          sr_d  = word[WORD_SIZE-9:0];
          cnt_d = last ? '0 : cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
          sr_q  <= '0;
        end else begin
          cnt_q <= cnt_d;
          sr_q  <= sr_d;
        end
      end
    end else begin : g_single
      assign word       = in_byte;
      assign word_valid = in_accept;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mcpu_prog_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mcpu_prog_loader : streams length/words/checksum into MCPU RAM, owns cpu_reset
// rev 1.0
// ---------------------------------------------------------------------------
module mcpu_prog_loader
  import mcpu_prog_loader_pkg::*;
#(
  parameter int WORD_SIZE     = MCPU_WORD_SIZE,
  parameter int ADDR_SIZE     = MCPU_ADDR_SIZE,
  parameter int RAM_SIZE      = 256,
  parameter int CLEAR_ON_LOAD = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_SIZE:0]   words_loaded
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR  = ADDR_SIZE'(RAM_SIZE - 1);
  localparam logic [WORD_SIZE:0]   RAM_SIZE_W = (WORD_SIZE + 1)'(RAM_SIZE);

  ld_state_t              state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
  logic                   cpu_reset_q, cpu_reset_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [ADDR_SIZE:0]     words_loaded_q, words_loaded_d;
  logic [ADDR_SIZE:0]     n_q, n_d;
  logic [7:0]             cs_q, cs_d;

  logic                   xfer;
  logic                   pk_accept;
  logic                   pk_clear;
  logic [WORD_SIZE-1:0]   pk_word;
  logic                   pk_valid;
  logic [ADDR_SIZE:0]     wl_next;

  assign xfer      = in_valid && in_ready_q;
  assign pk_accept = xfer && ((state_q == ST_LEN) || (state_q == ST_DATA));
  assign wl_next   = words_loaded_q + (ADDR_SIZE + 1)'(1);

  mcpu_word_packer #(
    .WORD_SIZE (WORD_SIZE)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .in_accept  (pk_accept),
    .in_byte    (in_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_comb begin
    state_d        = state_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    words_loaded_d = words_loaded_q;
    n_d            = n_q;
    cs_d           = cs_q;
    pk_clear       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          pk_clear       = 1'b1;
          cs_d           = '0;
          words_loaded_d = '0;
          if (CLEAR_ON_LOAD != 0) begin
            state_d     = ST_CLEAR;
            mem_we_d    = 1'b1;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
          end else begin
            state_d = ST_LEN;
          end
        end
      end
      ST_CLEAR: begin
        if (mem_addr_q == LAST_ADDR) begin
          state_d = ST_LEN;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_SIZE'(1);
        end
      end
      ST_LEN: begin
        if (pk_valid) begin
          n_d = (ADDR_SIZE + 1)'(pk_word);
          if ({1'b0, pk_word} > RAM_SIZE_W) begin
            state_d = ST_ERR;
          end else if (pk_word == '0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (pk_valid) begin
          mem_we_d       = 1'b1;
          mem_addr_d     = words_loaded_q[ADDR_SIZE-1:0];
          mem_wdata_d    = pk_word;
          words_loaded_d = wl_next;
          if (wl_next == n_q) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (xfer) begin
          state_d = (in_data == cs_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // checksum covers length and data bytes, never the checksum byte itself
    if (pk_accept) begin
      cs_d = cs_q ^ in_data;
    end

    in_ready_d  = st_accepts(state_d);
    busy_d      = st_busy(state_d);
    cpu_reset_d = (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      in_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_reset_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
      n_q            <= '0;
      cs_q           <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_reset_q    <= cpu_reset_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      words_loaded_q <= words_loaded_d;
      n_q            <= n_d;
      cs_q           <= cs_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_mcpu_prog_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mcpu_prog_loader : table vectors, hand sequences and random loads vs model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_mcpu_prog_loader;

  localparam int WS = 16;
  localparam int AS = 8;
  localparam int RS = 256;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, cpu_reset, busy, done, error;
  logic [AS-1:0] mem_addr;
  logic [WS-1:0] mem_wdata;
  logic [AS:0]   words_loaded;

  int checks   = 0;
  int failures = 0;

  logic [23:0] wr_q[$];
  logic [15:0] ram [RS];
  logic [7:0]  stream[$];
  logic [15:0] exp_words[$];
  int          m_consumed;

  typedef struct {
    logic [63:0] b;
    int          nb;
    bit          e_done;
    bit          e_err;
    int          e_words;
    logic [15:0] m0;
    logic [15:0] m1;
  } vec_t;
  vec_t vecs[$];

  mcpu_prog_loader #(
    .WORD_SIZE(WS), .ADDR_SIZE(AS), .RAM_SIZE(RS), .CLEAR_ON_LOAD(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      ram[mem_addr] = mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Parse the stream: length, N words, checksum byte.
  task automatic run_model();
    int         n;
    logic [7:0] cs;
    exp_words.delete();
    n  = int'({stream[0], stream[1]});
    cs = stream[0] ^ stream[1];
    if (n > RS) begin
      m_consumed = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      exp_words.push_back({stream[2 + 2*k], stream[3 + 2*k]});
      cs = cs ^ stream[2 + 2*k] ^ stream[3 + 2*k];
    end
    m_consumed = 3 + 2*n;
  endtask

  task automatic build_stream(input int n, input logic [7:0] corrupt);
    logic [7:0] cs, b;
    logic [15:0] n16;
    stream.delete();
    n16 = 16'(n);
    stream.push_back(n16[15:8]);
    stream.push_back(n16[7:0]);
    cs = n16[15:8] ^ n16[7:0];
    if (n <= RS) begin
      for (int i = 0; i < 2*n; i++) begin
        b  = 8'($urandom_range(255, 0));
        cs = cs ^ b;
        stream.push_back(b);
      end
      stream.push_back(cs ^ corrupt);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok, output int waits);
    int g;
    g     = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
    waits = 0;
    ok    = 1'b0;
    repeat (g) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run_load(input string tag, input int gap, input int start_at,
                          input bit e_done, input bit e_err, input int e_words,
                          output int waits_tail);
    bit ok;
    int w, errs;
    logic [23:0] exp;
    run_model();
    waits_tail = 0;
    @(negedge clk);
    wr_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".start_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, ".start_done"}, 32'(done), 32'd0);
    chk({tag, ".start_error"}, 32'(error), 32'd0);
    chk({tag, ".start_words"}, 32'(words_loaded), 32'd0);
    chk({tag, ".start_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < m_consumed; i++) begin
      if (i == start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".ignored_start_busy"}, 32'(busy), 32'd1);
      end
      send_byte(stream[i], gap, ok, w);
      if (i > 0) waits_tail += w;
      if (!ok) break;
    end
    repeat (3) @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".error"}, 32'(error), 32'(e_err));
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(!e_done));
    chk({tag, ".words_loaded"}, 32'(words_loaded), 32'(e_words));
    chk({tag, ".in_ready_end"}, 32'(in_ready), 32'd0);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".write_count"}, 32'(wr_q.size()), 32'(RS + exp_words.size()));
    errs = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      if (i < RS) exp = {8'(i), 16'h0000};
      else if (i - RS < exp_words.size()) exp = {8'(i - RS), exp_words[i - RS]};
      else exp = 24'hxxxxxx;
      if (wr_q[i] !== exp) errs++;
    end
    chk({tag, ".write_contents_bad"}, 32'(errs), 32'd0);
  endtask

  task automatic add_vec(input logic [63:0] b, input int nb, input bit d, input bit e,
                         input int w, input logic [15:0] m0, input logic [15:0] m1);
    vec_t v;
    v.b = b; v.nb = nb; v.e_done = d; v.e_err = e; v.e_words = w; v.m0 = m0; v.m1 = m1;
    vecs.push_back(v);
  endtask

  initial begin
    int         waits;
    bit         ok;
    int         n;
    logic [7:0] corrupt;
    bit         e_done;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.error", 32'(error), 32'd0);
    chk("reset.mem_we", 32'(mem_we), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // XOR of 00 02 80 03 82 01 is 0x02, so 0x02 is the matching checksum.
    add_vec(64'h0002_8003_8201_0200, 7, 1, 0, 2, 16'h8003, 16'h8201);
    add_vec(64'h0002_8003_8201_5A00, 7, 0, 1, 2, 16'h8003, 16'h8201);
    add_vec(64'h0101_0000_0000_0000, 2, 0, 1, 0, 16'h0000, 16'h0000);
    add_vec(64'h0000_0000_0000_0000, 3, 1, 0, 0, 16'h0000, 16'h0000);
    add_vec(64'h0001_1234_2700_0000, 5, 1, 0, 1, 16'h1234, 16'h0000);

    foreach (vecs[r]) begin
      stream.delete();
      for (int i = 0; i < vecs[r].nb; i++) stream.push_back(vecs[r].b[63 - 8*i -: 8]);
      run_load($sformatf("vec%0d", r), 0, -1, vecs[r].e_done, vecs[r].e_err,
               vecs[r].e_words, waits);
      chk($sformatf("vec%0d.ram0", r), 32'(ram[0]), 32'(vecs[r].m0));
      chk($sformatf("vec%0d.ram1", r), 32'(ram[1]), 32'(vecs[r].m1));
    end

    // Same program with random bubbles between bytes
    stream = '{8'h00, 8'h02, 8'h80, 8'h03, 8'h82, 8'h01, 8'h02};
    run_load("gaps", 4, -1, 1, 0, 2, waits);
    chk("gaps.ram0", 32'(ram[0]), 32'h8003);
    chk("gaps.ram1", 32'(ram[1]), 32'h8201);

    // start pulsed mid-DATA must be ignored
    run_load("start_in_data", 0, 4, 1, 0, 2, waits);
    chk("start_in_data.ram1", 32'(ram[1]), 32'h8201);

    // reset after the first data word, then a clean reload
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(stream[i], 0, ok, waits);
    @(negedge clk);
    chk("mid_reset.words_before", 32'(words_loaded), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_reset.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_reset.in_ready", 32'(in_ready), 32'd0);
    chk("mid_reset.busy", 32'(busy), 32'd0);
    chk("mid_reset.words", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    run_load("after_reset", 0, -1, 1, 0, 2, waits);
    chk("after_reset.ram0", 32'(ram[0]), 32'h8003);

    // Full RAM, back-to-back bytes: no stalls once the length phase starts
    build_stream(RS, 8'h00);
    run_load("full_ram", 0, -1, 1, 0, RS, waits);
    chk("full_ram.stall_cycles", 32'(waits), 32'd0);

    for (int it = 0; it < 8; it++) begin
      n       = ($urandom_range(9, 0) == 0) ? RS + 1 + int'($urandom_range(20, 0))
                                            : int'($urandom_range(6, 0));
      corrupt = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      build_stream(n, corrupt);
      e_done  = (n <= RS) && (corrupt == 8'h00);
      run_load($sformatf("rand%0d", it), 3, -1, e_done, !e_done, (n <= RS) ? n : 0, waits);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
